// File: rtl/fp_mac_dot_seq.sv
// Streaming dot-product sequencer around a fused multiply-add unit: latches a command,
// feeds accepted (a,b) pairs with c = running accumulator, and returns the final sum.
module fp_mac_dot_seq #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int cnt_width = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_valid,
  output logic                                 start_ready,
  input  logic [cnt_width-1:0]                 start_len,
  input  logic [sig_width+exp_width:0]         start_init,
  input  logic [2:0]                           start_rnd,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [sig_width+exp_width:0]         in_a,
  input  logic [sig_width+exp_width:0]         in_b,
  output logic [sig_width+exp_width:0]         mac_a,
  output logic [sig_width+exp_width:0]         mac_b,
  output logic [sig_width+exp_width:0]         mac_c,
  output logic [2:0]                           mac_rnd,
  output logic                                 mac_dg_ctrl,
  input  logic [sig_width+exp_width:0]         mac_z,
  input  logic [7:0]                           mac_status,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [sig_width+exp_width:0]         out_z,
  output logic [7:0]                           out_status
);

  localparam int W = sig_width + exp_width + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t               state;
  logic [W-1:0]         acc;
  logic [W-1:0]         a_hold;
  logic [W-1:0]         b_hold;
  logic [cnt_width-1:0] remaining;
  logic [2:0]           rnd_q;
  logic [7:0]           stat_q;
  logic                 pair_fire;

  assign pair_fire   = in_valid & in_ready;
  assign mac_dg_ctrl = pair_fire;

  // Operand buses only move on accepted pairs so the gated datapath sees no toggling.
  assign mac_a = pair_fire ? in_a : a_hold;
  assign mac_b = pair_fire ? in_b : b_hold;

  assign mac_c      = acc;
  assign mac_rnd    = rnd_q;
  assign out_z      = acc;
  assign out_status = stat_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      a_hold      <= '0;
      b_hold      <= '0;
      remaining   <= '0;
      rnd_q       <= '0;
      stat_q      <= '0;
      start_ready <= 1'b1;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc         <= start_init;
            rnd_q       <= start_rnd;
            stat_q      <= '0;
            remaining   <= start_len;
            start_ready <= 1'b0;
            if (start_len != '0) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (pair_fire) begin
            acc         <= mac_z;
            a_hold      <= in_a;
            b_hold      <= in_b;
            // Exception flags are sticky; the zero flag describes only the latest sum.
            stat_q[7:1] <= stat_q[7:1] | mac_status[7:1];
            stat_q[0]   <= mac_status[0];
            if (remaining != '0) begin
              remaining <= remaining - cnt_width'(1);
            end
            if (remaining == cnt_width'(1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            start_ready <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          in_ready    <= 1'b0;
          out_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mac_dot_seq.sv
// Bench for fp_mac_dot_seq: a behavioural single-precision fused MAC stands in for the
// hardware MAC; directed vectors come from a table, random vectors from a real-number sum.
module tb_fp_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] start_len;
  logic [31:0] start_init;
  logic [2:0]  start_rnd;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] mac_a, mac_b, mac_c;
  logic [2:0]  mac_rnd;
  logic        mac_dg_ctrl;
  logic [31:0] mac_z;
  logic [7:0]  mac_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;

  int total = 0;
  int bad = 0;
  int dg_count = 0;
  logic [31:0] pa [8];
  logic [31:0] pb [8];
  logic [39:0] mac_res;

  fp_mac_dot_seq #(.sig_width(23), .exp_width(8), .cnt_width(16)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len),
    .start_init(start_init), .start_rnd(start_rnd),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_rnd(mac_rnd),
    .mac_dg_ctrl(mac_dg_ctrl), .mac_z(mac_z), .mac_status(mac_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_status(out_status)
  );

  always #5 clk = ~clk;

  // Single-precision helpers; status byte follows the usual MAC encoding:
  // [0] zero, [1] infinity, [2] invalid, [3] tiny, [4] huge, [5] inexact.
  function automatic real sp2real(input logic [31:0] x);
    int  e;
    real m;
    real r;
    if (x[30:0] == 31'd0) return 0.0;
    e = int'(x[30:23]);
    m = real'(x[22:0]) / 8388608.0;
    if (e == 0) r = m * (2.0 ** (-126.0));
    else        r = (1.0 + m) * (2.0 ** real'(e - 127));
    return x[31] ? -r : r;
  endfunction

  function automatic logic [39:0] real2sp(input real r);
    logic [63:0] d;
    logic        sgn;
    int          de;
    logic [23:0] m24;
    logic [28:0] rest;
    logic [24:0] m25;
    logic        up;
    d   = $realtobits(r);
    sgn = d[63];
    if (d[62:0] == 63'd0) return {8'h01, sgn, 31'd0};
    de = int'(d[62:52]) - 1023;
    if (de < -126) return {8'h29, sgn, 31'd0};
    m24  = {1'b1, d[51:29]};
    rest = d[28:0];
    up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && m24[0]);
    m25  = {1'b0, m24} + 25'(up);
    if (m25[24]) begin
      de++;
      m25 = m25 >> 1;
    end
    if (de > 127) return {8'h32, sgn, 8'hFF, 23'd0};
    return {(rest != 29'd0) ? 8'h20 : 8'h00, sgn, 8'(de + 127), m25[22:0]};
  endfunction

  function automatic logic [39:0] mac_model(input logic [31:0] a, b, c);
    logic a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_zero, b_zero, p_sign;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    c_nan  = (c[30:23] == 8'hFF) && (c[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    c_inf  = (c[30:23] == 8'hFF) && (c[22:0] == 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    p_sign = a[31] ^ b[31];
    if (a_nan || b_nan || c_nan) return {8'h04, 32'h7FC00000};
    if ((a_inf || b_inf) && (a_zero || b_zero)) return {8'h04, 32'h7FC00000};
    if ((a_inf || b_inf) && c_inf && (p_sign != c[31])) return {8'h04, 32'h7FC00000};
    if (a_inf || b_inf) return {8'h02, p_sign, 8'hFF, 23'd0};
    if (c_inf) return {8'h02, c};
    return real2sp(sp2real(a) * sp2real(b) + sp2real(c));
  endfunction

  always_comb mac_res = mac_model(mac_a, mac_b, mac_c);
  assign mac_z      = mac_res[31:0];
  assign mac_status = mac_res[39:32];

  always @(negedge clk) if (mac_dg_ctrl) dg_count = dg_count + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: run exceeded time bound");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Runs one command from IDLE; entered and left at posedge+1.
  task automatic run_vec(input string tag, input int len, input logic [31:0] init,
                         input logic [2:0] rnd, input int gap, input int hold,
                         input logic [31:0] exp_z, input logic [7:0] exp_st);
    dg_count    = 0;
    start_valid = 1'b1;
    start_len   = 16'(len);
    start_init  = init;
    start_rnd   = rnd;
    @(negedge clk);
    check({tag, "/start_ready"}, 64'(start_ready), 64'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_a     = $urandom;
          in_b     = $urandom;
          @(negedge clk);
          check({tag, "/bubble_dg"}, 64'(mac_dg_ctrl), 64'd0);
          check({tag, "/bubble_a"}, 64'(mac_a), 64'(pa[i-1]));
          check({tag, "/bubble_b"}, 64'(mac_b), 64'(pb[i-1]));
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      @(negedge clk);
      check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "/early_valid"}, 64'(out_valid), 64'd0);
      check({tag, "/mac_a"}, 64'(mac_a), 64'(pa[i]));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      out_ready   = (h == hold);
      start_valid = (h < hold);
      start_len   = 16'($urandom_range(0, 5));
      start_init  = $urandom;
      @(negedge clk);
      check({tag, "/out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "/out_z"}, 64'(out_z), 64'(exp_z));
      check({tag, "/out_status"}, 64'(out_status), 64'(exp_st));
      check({tag, "/start_ready_busy"}, 64'(start_ready), 64'd0);
      check({tag, "/in_ready_done"}, 64'(in_ready), 64'd0);
      if (h == 0) begin
        check({tag, "/mac_c"}, 64'(mac_c), 64'(exp_z));
        check({tag, "/mac_rnd"}, 64'(mac_rnd), 64'(rnd));
      end
      @(posedge clk); #1;
    end
    out_ready   = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "/back_idle"}, 64'(start_ready), 64'd1);
    check({tag, "/dg_cycles"}, 64'(dg_count), 64'(len));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_half(input bit allow_zero, input bit allow_neg);
    int          k;
    real         r;
    logic [39:0] t;
    k = $urandom_range(allow_zero ? 0 : 1, 15);
    r = real'(k) / 2.0;
    if (allow_neg && ($urandom_range(0, 1) == 1)) r = -r;
    t = real2sp(r);
    return t[31:0];
  endfunction

  typedef struct {
    int          len;
    logic [31:0] init;
    logic [2:0]  rnd;
    logic [31:0] a [4];
    logic [31:0] b [4];
    int          gap;
    int          hold;
    logic [31:0] exp_z;
    logic [7:0]  exp_st;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{len: 3, init: 32'h0, rnd: 3'd0,
                a: '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h0},
                b: '{32'h40000000, 32'h40000000, 32'h40000000, 32'h0},
                gap: 0, hold: 5, exp_z: 32'h40C00000, exp_st: 8'h00};
    vecs[1] = '{len: 0, init: 32'h3F800000, rnd: 3'd5,
                a: '{32'h0, 32'h0, 32'h0, 32'h0}, b: '{32'h0, 32'h0, 32'h0, 32'h0},
                gap: 0, hold: 1, exp_z: 32'h3F800000, exp_st: 8'h00};
    vecs[2] = '{len: 2, init: 32'h0, rnd: 3'd0,
                a: '{32'h3F800000, 32'h40000000, 32'h0, 32'h0},
                b: '{32'h40400000, 32'hBFC00000, 32'h0, 32'h0},
                gap: 4, hold: 0, exp_z: 32'h00000000, exp_st: 8'h01};
    vecs[3] = '{len: 1, init: 32'h0, rnd: 3'd0,
                a: '{32'h7F7FFFFF, 32'h0, 32'h0, 32'h0},
                b: '{32'h40000000, 32'h0, 32'h0, 32'h0},
                gap: 0, hold: 0, exp_z: 32'h7F800000, exp_st: 8'h32};
    vecs[4] = '{len: 2, init: 32'h0, rnd: 3'd0,
                a: '{32'h7F7FFFFF, 32'h3F800000, 32'h0, 32'h0},
                b: '{32'h40000000, 32'h3F800000, 32'h0, 32'h0},
                gap: 1, hold: 0, exp_z: 32'h7F800000, exp_st: 8'h32};
    vecs[5] = '{len: 4, init: 32'h3F800000, rnd: 3'd0,
                a: '{32'h40000000, 32'hBF800000, 32'h3F000000, 32'h40400000},
                b: '{32'h40000000, 32'h40000000, 32'h40800000, 32'hBF800000},
                gap: 0, hold: 0, exp_z: 32'h40000000, exp_st: 8'h00};

    rst = 1'b1;
    start_valid = 1'b0; start_len = '0; start_init = '0; start_rnd = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset/start_ready", 64'(start_ready), 64'd1);
    check("reset/in_ready", 64'(in_ready), 64'd0);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/dg_ctrl", 64'(mac_dg_ctrl), 64'd0);
    check("reset/mac_a", 64'(mac_a), 64'd0);
    check("reset/mac_c", 64'(mac_c), 64'd0);
    check("reset/mac_rnd", 64'(mac_rnd), 64'd0);
    check("reset/out_status", 64'(out_status), 64'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        pa[i] = vecs[v].a[i];
        pb[i] = vecs[v].b[i];
      end
      run_vec($sformatf("vec%0d", v), vecs[v].len, vecs[v].init, vecs[v].rnd,
              vecs[v].gap, vecs[v].hold, vecs[v].exp_z, vecs[v].exp_st);
    end

    // Reset after the first of four pairs: partial sum discarded, no result.
    start_valid = 1'b1; start_len = 16'd4; start_init = 32'h40000000; start_rnd = 3'd0;
    @(posedge clk); #1;
    start_valid = 1'b0; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst/start_ready", 64'(start_ready), 64'd1);
    check("midrst/in_ready", 64'(in_ready), 64'd0);
    check("midrst/mac_c", 64'(mac_c), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      @(negedge clk);
      check("midrst/no_valid", 64'(out_valid), 64'd0);
      check("midrst/no_dg", 64'(mac_dg_ctrl), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pa[0] = 32'h40000000; pb[0] = 32'h40000000;
    run_vec("after_rst", 1, 32'h0, 3'd0, 0, 0, 32'h40800000, 8'h00);

    // Reset while a result is waiting in DONE.
    start_valid = 1'b1; start_len = 16'd0; start_init = 32'h40400000;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(negedge clk);
    check("donerst/pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("donerst/out_valid", 64'(out_valid), 64'd0);
    check("donerst/start_ready", 64'(start_ready), 64'd1);
    @(posedge clk); #1;

    // Random vectors: exact half-integer values, reference is a plain real-number sum.
    for (int n = 0; n < 20; n++) begin
      int          len;
      logic [31:0] init;
      real         sum;
      logic [39:0] t;
      logic [7:0]  st;
      len  = $urandom_range(0, 6);
      init = rand_half(1'b1, 1'b0);
      sum  = sp2real(init);
      for (int i = 0; i < len; i++) begin
        pa[i] = rand_half(1'b0, 1'b1);
        pb[i] = rand_half(1'b0, 1'b1);
        sum   = sum + sp2real(pa[i]) * sp2real(pb[i]);
      end
      t  = real2sp(sum);
      st = ((len != 0) && (sum == 0.0)) ? 8'h01 : 8'h00;
      run_vec($sformatf("rnd%0d", n), len, init, 3'd0, $urandom_range(0, 2),
              $urandom_range(0, 2), t[31:0], st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
